life_grid_engine: RTL and testbench
===================================

Name: life_grid_engine

Overview:
Parametrised Conway's Game of Life engine holding a GRID_W x GRID_H cell array in two ping-pong bit buffers.
- On a step request it sweeps the active buffer one cell per cycle, applies rule B3/S23, writes the shadow buffer, then swaps buffers.
- Exposes a registered pixel-read port for the VGA draw path and a single-cell write port for user edits.
- Sits between the control FSM (step/clear requests) and the VGA plotter in main.

Parameters:
GRID_W, 160, grid width in cells (>=3)
GRID_H, 120, grid height in cells (>=3)
SEED_COL, 50, column set alive by reset/clear; SEED_COL >= GRID_W gives an all-dead grid
GEN_W, 16, generation counter width
X_W, $clog2(GRID_W), x coordinate width (derived, localparam)
Y_W, $clog2(GRID_H), y coordinate width (derived, localparam)

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous, active-low reset
clear_req  in  1  pulse: re-seed grid with the SEED_COL pattern
step_req  in  1  pulse: compute one generation
wr_en  in  1  single-cell write strobe
wr_x  in  X_W  write x
wr_y  in  Y_W  write y
wr_cell  in  1  value to write
rd_x  in  X_W  read x
rd_y  in  Y_W  read y
rd_cell  out  1  active-buffer cell at (rd_x,rd_y), registered
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a step or clear completes
gen_count  out  GEN_W  generations computed since last reset/clear

Behaviour:
- States: CLEAR, IDLE, STEP, SWAP.
- Scan order for CLEAR and STEP: x fastest (0..GRID_W-1), then y (0..GRID_H-1).
- Reset (reset_n=0 at a clock edge): state<=CLEAR, scan x/y<=0, active select<=0, gen_count<=0, done<=0, rd_cell<=0. Buffer contents are not reset directly; CLEAR rewrites them.
- CLEAR: each cycle writes the active buffer at (x,y) with 1 if x==SEED_COL, else 0.
  - Runs exactly GRID_W*GRID_H cycles, then goes to IDLE.
  - done pulses on the cycle IDLE is entered; gen_count<=0.
- IDLE:
  - clear_req goes to CLEAR; clear_req wins over step_req.
  - step_req goes to STEP with scan counters zeroed.
  - wr_en with in-range coordinates writes the active buffer that cycle. Out-of-range coordinates are ignored.
  - wr_en in the same cycle as step_req is committed before the first cell is evaluated.
- STEP: each cycle computes n = the live count of the 8 neighbours of (x,y) in the active buffer, as a 4-bit value.
  - Next cell = (n==3) | (cur & n==2), written to the shadow buffer at (x,y).
  - Neighbours outside the grid count as dead (see Optional Feature).
  - The active buffer is never modified during STEP.
  - After cell (GRID_W-1,GRID_H-1), goes to SWAP.
- SWAP, one cycle: toggle active select, gen_count<=gen_count+1 (wraps mod 2^GEN_W), pulse done, go to IDLE.
- Latency: one step is GRID_W*GRID_H+1 cycles from the first STEP cycle to done; busy deasserts the same cycle done pulses.
- Requests while busy:
  - step_req, clear_req and wr_en are ignored, not queued.
  - A reset mid-STEP or mid-CLEAR aborts and restarts CLEAR.
- Read port:
  - rd_cell <= active[rd_x][rd_y] every cycle in all states; 1-cycle latency.
  - Out-of-range coordinates return 0.
  - During CLEAR it shows the partially cleared buffer; during STEP it shows the previous generation.

Optional Feature:
LIFE_WRAP_EN
- Defined: toroidal grid. A neighbour at x=-1 maps to GRID_W-1 and x=GRID_W maps to 0; the same applies to y.
- Undefined: fixed dead border; out-of-grid neighbours contribute 0.

Test Plan:
- Reset, defaults, run 160*120 cycles -> busy falls and done pulses once; rd(50,0)=1, rd(50,119)=1, rd(49,60)=0, rd(51,60)=0; gen_count=0.
- GRID_W=8, GRID_H=8, SEED_COL=8, then write (3,2),(3,3),(3,4) and step -> done after 65 cycles; (2,3),(3,3),(4,3) alive, (3,2),(3,4) dead, gen_count=1; second step restores the vertical blinker, gen_count=2.
- Defaults, no wrap, one step -> cols 49..51 alive for rows 1..118; (50,0), (50,119), (49,0) dead.
- Defaults with LIFE_WRAP_EN, one step -> cols 49, 50 and 51 alive for all rows 0..119.
- step_req and clear_req in the same IDLE cycle -> CLEAR taken, gen_count=0; a step_req pulsed mid-STEP is ignored and yields exactly one done.
- reset_n low for one cycle halfway through STEP -> state CLEAR, gen_count=0, and the grid after CLEAR equals the seed pattern.

Source files
------------

// File: rtl/life_grid_engine.sv
// Game of Life engine (B3/S23) over two ping-pong bit planes, one cell per cycle; step done GRID_W*GRID_H+1 cycles after the first STEP cycle.
// Requests are dropped while busy; define LIFE_WRAP_EN for a toroidal grid, otherwise the border is dead.
module life_grid_engine #(
  parameter int GRID_W   = 160,
  parameter int GRID_H   = 120,
  parameter int SEED_COL = 50,
  parameter int GEN_W    = 16,
  localparam int X_W     = $clog2(GRID_W),
  localparam int Y_W     = $clog2(GRID_H)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_req,
  input  logic             step_req,
  input  logic             wr_en,
  input  logic [X_W-1:0]   wr_x,
  input  logic [Y_W-1:0]   wr_y,
  input  logic             wr_cell,
  input  logic [X_W-1:0]   rd_x,
  input  logic [Y_W-1:0]   rd_y,
  output logic             rd_cell,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_STEP, S_SWAP} state_t;

  localparam logic [X_W-1:0] X_LAST = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(GRID_H - 1);

  state_t           state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             sel_q, sel_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             done_q, done_d;
  logic             rd_cell_q, rd_cell_d;

  // grid_q[plane][row][col]; sel_q names the plane being displayed and evolved from
  logic [GRID_W-1:0] grid_q [2][GRID_H];

  logic           cell_we;
  logic           cell_wsel;
  logic [X_W-1:0] cell_wx;
  logic [Y_W-1:0] cell_wy;
  logic           cell_wdat;

  logic [3:0] nbr_cnt;
  logic       cur_cell;
  logic       next_cell;
  logic       scan_last;
  logic       wr_in_range;
  logic       rd_in_range;

  function automatic logic cell_at(input logic s, input int cx, input int cy);
`ifdef LIFE_WRAP_EN
    int wx;
    int wy;
    wx = (cx + GRID_W) % GRID_W;
    wy = (cy + GRID_H) % GRID_H;
    return grid_q[s][Y_W'(wy)][X_W'(wx)];
`else
    if (cx < 0 || cx >= GRID_W || cy < 0 || cy >= GRID_H) return 1'b0;
    return grid_q[s][Y_W'(cy)][X_W'(cx)];
`endif
  endfunction

  always_comb begin
    nbr_cnt = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx != 0 || dy != 0)
          nbr_cnt = nbr_cnt + 4'(cell_at(sel_q, int'(x_q) + dx, int'(y_q) + dy));
      end
    end
    cur_cell  = cell_at(sel_q, int'(x_q), int'(y_q));
    next_cell = (nbr_cnt == 4'd3) | (cur_cell & (nbr_cnt == 4'd2));
  end

  assign scan_last   = (x_q == X_LAST) && (y_q == Y_LAST);
  assign wr_in_range = (int'(wr_x) < GRID_W) && (int'(wr_y) < GRID_H);
  assign rd_in_range = (int'(rd_x) < GRID_W) && (int'(rd_y) < GRID_H);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    sel_d     = sel_q;
    gen_d     = gen_q;
    done_d    = 1'b0;
    cell_we   = 1'b0;
    cell_wsel = sel_q;
    cell_wx   = x_q;
    cell_wy   = y_q;
    cell_wdat = 1'b0;

    // raster advance shared by CLEAR and STEP; overridden on the last cell
    if (state_q == S_CLEAR || state_q == S_STEP) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    case (state_q)
      S_CLEAR: begin
        cell_we   = 1'b1;
        cell_wdat = (int'(x_q) == SEED_COL);
        if (scan_last) begin
          state_d = S_IDLE;
          x_d     = '0;
          y_d     = '0;
          gen_d   = '0;
          done_d  = 1'b1;
        end
      end
      S_IDLE: begin
        if (wr_en && wr_in_range) begin
          cell_we   = 1'b1;
          cell_wx   = wr_x;
          cell_wy   = wr_y;
          cell_wdat = wr_cell;
        end
        if (clear_req) begin
          state_d = S_CLEAR;
          x_d     = '0;
          y_d     = '0;
        end else if (step_req) begin
          state_d = S_STEP;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_STEP: begin
        cell_we   = 1'b1;
        cell_wsel = ~sel_q;
        cell_wdat = next_cell;
        if (scan_last) begin
          state_d = S_SWAP;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_SWAP: begin
        sel_d   = ~sel_q;
        gen_d   = gen_q + 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase

    rd_cell_d = rd_in_range ? grid_q[sel_q][rd_y][rd_x] : 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_CLEAR;
      x_q       <= '0;
      y_q       <= '0;
      sel_q     <= 1'b0;
      gen_q     <= '0;
      done_q    <= 1'b0;
      rd_cell_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sel_q     <= sel_d;
      gen_q     <= gen_d;
      done_q    <= done_d;
      rd_cell_q <= rd_cell_d;
    end
  end

  // cell planes carry no reset; CLEAR repopulates them
  always_ff @(posedge clock) begin
    if (cell_we) grid_q[cell_wsel][cell_wy][cell_wx] <= cell_wdat;
  end

  assign rd_cell   = rd_cell_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign gen_count = gen_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Bench for life_grid_engine: a 160x120 default instance (A) and an 8x8 all-dead-seed instance (B) against a cell-array model.
module tb_life_grid_engine;

  logic clk;

  logic       a_rst_n, a_clear, a_step, a_wr_en, a_wr_cell, a_rd_cell, a_busy, a_done;
  logic [7:0] a_wr_x, a_rd_x;
  logic [6:0] a_wr_y, a_rd_y;
  logic [15:0] a_gen;

  logic       b_rst_n, b_clear, b_step, b_wr_en, b_wr_cell, b_rd_cell, b_busy, b_done;
  logic [2:0] b_wr_x, b_rd_x, b_wr_y, b_rd_y;
  logic [15:0] b_gen;

  life_grid_engine u_big (
    .clock(clk), .reset_n(a_rst_n), .clear_req(a_clear), .step_req(a_step),
    .wr_en(a_wr_en), .wr_x(a_wr_x), .wr_y(a_wr_y), .wr_cell(a_wr_cell),
    .rd_x(a_rd_x), .rd_y(a_rd_y), .rd_cell(a_rd_cell),
    .busy(a_busy), .done(a_done), .gen_count(a_gen)
  );

  life_grid_engine #(.GRID_W(8), .GRID_H(8), .SEED_COL(8), .GEN_W(16)) u_small (
    .clock(clk), .reset_n(b_rst_n), .clear_req(b_clear), .step_req(b_step),
    .wr_en(b_wr_en), .wr_x(b_wr_x), .wr_y(b_wr_y), .wr_cell(b_wr_cell),
    .rd_x(b_rd_x), .rd_y(b_rd_y), .rd_cell(b_rd_cell),
    .busy(b_busy), .done(b_done), .gen_count(b_gen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run = 0;
  int tests_failed = 0;

  bit mdl [0:119][0:159];
  bit nxt [0:119][0:159];
  int mw, mh;
  int gen_exp;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_seed(input int col);
    for (int y = 0; y < mh; y++)
      for (int x = 0; x < mw; x++)
        mdl[y][x] = (x == col);
  endtask

  task automatic model_step();
    for (int y = 0; y < mh; y++) begin
      for (int x = 0; x < mw; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int nx, ny;
            nx = x + dx;
            ny = y + dy;
            if (dx == 0 && dy == 0) continue;
`ifdef LIFE_WRAP_EN
            nx = (nx + mw) % mw;
            ny = (ny + mh) % mh;
`else
            if (nx < 0 || nx >= mw || ny < 0 || ny >= mh) continue;
`endif
            n += int'(mdl[ny][nx]);
          end
        end
        nxt[y][x] = (n == 3) || (mdl[y][x] && n == 2);
      end
    end
    for (int y = 0; y < mh; y++)
      for (int x = 0; x < mw; x++)
        mdl[y][x] = nxt[y][x];
  endtask

  task automatic set_in(input int sel, input bit st, input bit cl, input bit we,
                        input int wx, input int wy, input bit wc);
    if (sel == 0) begin
      a_step = st; a_clear = cl; a_wr_en = we;
      a_wr_x = 8'(wx); a_wr_y = 7'(wy); a_wr_cell = wc;
    end else begin
      b_step = st; b_clear = cl; b_wr_en = we;
      b_wr_x = 3'(wx); b_wr_y = 3'(wy); b_wr_cell = wc;
    end
  endtask

  task automatic set_rd(input int sel, input int x, input int y);
    if (sel == 0) begin a_rd_x = 8'(x); a_rd_y = 7'(y); end
    else begin b_rd_x = 3'(x); b_rd_y = 3'(y); end
  endtask

  function automatic int get_rd(input int sel);   return sel == 0 ? int'(a_rd_cell) : int'(b_rd_cell); endfunction
  function automatic int get_done(input int sel); return sel == 0 ? int'(a_done) : int'(b_done); endfunction
  function automatic int get_busy(input int sel); return sel == 0 ? int'(a_busy) : int'(b_busy); endfunction
  function automatic int get_gen(input int sel);  return sel == 0 ? int'(a_gen) : int'(b_gen); endfunction

  // drive one cycle of request inputs, latched by the next edge
  task automatic start_op(input int sel, input bit st, input bit cl, input bit we,
                          input int wx, input int wy, input bit wc);
    set_in(sel, st, cl, we, wx, wy, wc);
    @(posedge clk); #1;
    set_in(sel, 0, 0, 0, 0, 0, 0);
  endtask

  // counts edges after the latching edge until done; optionally pokes requests mid-operation
  task automatic wait_done(input int sel, input int budget, input int inject, output int cyc);
    bit got;
    got = 0;
    cyc = 0;
    while (!got && cyc < budget) begin
      if (cyc == inject)
        set_in(sel, 1, 1, 1, $urandom_range(0, mw - 1), $urandom_range(0, mh - 1), 1);
      @(posedge clk); #1;
      set_in(sel, 0, 0, 0, 0, 0, 0);
      cyc++;
      if (get_done(sel) != 0) got = 1;
    end
    if (!got) check("done_timeout", 0, 1);
  endtask

  task automatic check_pt(input int sel, input int x, input int y, input string tag);
    set_rd(sel, x, y);
    @(posedge clk); #1;
    check($sformatf("%s(%0d,%0d)", tag, x, y), get_rd(sel), int'(mdl[y][x]));
  endtask

  task automatic check_random(input int sel, input int n, input string tag);
    repeat (n) check_pt(sel, $urandom_range(0, mw - 1), $urandom_range(0, mh - 1), tag);
  endtask

  task automatic check_grid(input int sel, input string tag);
    for (int y = 0; y < mh; y++)
      for (int x = 0; x < mw; x++)
        check_pt(sel, x, y, tag);
  endtask

  initial begin
    int cyc;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0); set_in(1, 0, 0, 0, 0, 0, 0);
    set_rd(0, 0, 0); set_rd(1, 0, 0);

    // ---------------- instance A: 160x120, seed column 50 ----------------
    mw = 160; mh = 120;
    repeat (3) @(posedge clk);
    #1;
    check("a_rst_rd", get_rd(0), 0);
    check("a_rst_gen", get_gen(0), 0);
    check("a_rst_done", get_done(0), 0);
    check("a_rst_busy", get_busy(0), 1);
    a_rst_n = 1'b1;
    wait_done(0, 19300, -1, cyc);
    check("a_clear_lat", cyc, 160 * 120);
    check("a_clear_busy", get_busy(0), 0);
    check("a_clear_gen", get_gen(0), 0);
    @(posedge clk); #1;
    check("a_done_once", get_done(0), 0);
    model_seed(50);
    check_pt(0, 50, 0, "a_seed");
    check_pt(0, 50, 119, "a_seed");
    check_pt(0, 49, 60, "a_seed");
    check_pt(0, 51, 60, "a_seed");
    check_random(0, 40, "a_seed");

    set_rd(0, 200, 10);
    @(posedge clk); #1;
    check("a_rd_oob_x", get_rd(0), 0);
    set_rd(0, 50, 125);
    @(posedge clk); #1;
    check("a_rd_oob_y", get_rd(0), 0);
    start_op(0, 0, 0, 1, 170, 5, 1);
    start_op(0, 0, 0, 1, 5, 125, 1);

    gen_exp = 0;
    start_op(0, 1, 0, 0, 0, 0, 0);
    wait_done(0, 19300, -1, cyc);
    check("a_step_lat", cyc, 160 * 120 + 1);
    check("a_step_busy", get_busy(0), 0);
    gen_exp++;
    check("a_step_gen", get_gen(0), gen_exp);
    model_step();
    check_pt(0, 50, 0, "a_step");
    check_pt(0, 50, 119, "a_step");
    check_pt(0, 49, 0, "a_step");
    check_pt(0, 49, 1, "a_step");
    check_pt(0, 51, 118, "a_step");
    check_pt(0, 48, 60, "a_step");
    check_pt(0, 52, 60, "a_step");
    for (int x = 0; x < 160; x++) check_pt(0, x, 5, "a_step_row5");
    for (int y = 0; y < 120; y++) check_pt(0, 49, y, "a_step_col49");
    check_random(0, 60, "a_step");

    start_op(0, 1, 0, 0, 0, 0, 0);
    repeat (9600) @(posedge clk);
    #1;
    check("a_mid_busy", get_busy(0), 1);
    check("a_mid_gen", get_gen(0), gen_exp);
    a_rst_n = 1'b0;
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    check("a_mid_rst_gen", get_gen(0), 0);
    check("a_mid_rst_busy", get_busy(0), 1);
    wait_done(0, 19300, -1, cyc);
    check("a_reclear_lat", cyc, 160 * 120);
    check("a_reclear_gen", get_gen(0), 0);
    model_seed(50);
    for (int x = 0; x < 160; x++) check_pt(0, x, 60, "a_reclear_row");
    for (int y = 0; y < 120; y++) check_pt(0, 50, y, "a_reclear_col");
    check_random(0, 50, "a_reclear");

    // ---------------- instance B: 8x8, all-dead seed ----------------
    mw = 8; mh = 8;
    @(posedge clk); #1;
    check("b_rst_rd", get_rd(1), 0);
    check("b_rst_gen", get_gen(1), 0);
    b_rst_n = 1'b1;
    wait_done(1, 80, -1, cyc);
    check("b_clear_lat", cyc, 64);
    model_seed(8);
    check_grid(1, "b_seed");

    start_op(1, 0, 0, 1, 3, 2, 1); mdl[2][3] = 1;
    start_op(1, 0, 0, 1, 3, 3, 1); mdl[3][3] = 1;
    start_op(1, 1, 0, 1, 3, 4, 1); mdl[4][3] = 1;
    gen_exp = 0;
    for (int g = 0; g < 2; g++) begin
      wait_done(1, 80, -1, cyc);
      check("b_blink_lat", cyc, 65);
      gen_exp++;
      check("b_blink_gen", get_gen(1), gen_exp);
      model_step();
      check_grid(1, "b_blink");
      if (g == 0) start_op(1, 1, 0, 0, 0, 0, 0);
    end
    check_pt(1, 3, 2, "b_vert");
    check_pt(1, 3, 4, "b_vert");

    for (int it = 0; it < 12; it++) begin
      int nwr, inj;
      nwr = $urandom_range(4, 12);
      for (int k = 0; k < nwr; k++) begin
        int wx, wy;
        bit wc;
        wx = $urandom_range(0, 7);
        wy = $urandom_range(0, 7);
        wc = 1'($urandom_range(0, 1));
        mdl[wy][wx] = wc;
        start_op(1, (k == nwr - 1), 0, 1, wx, wy, wc);
      end
      inj = (it % 3 == 0) ? $urandom_range(2, 60) : -1;
      wait_done(1, 80, inj, cyc);
      check("b_rand_lat", cyc, 65);
      gen_exp++;
      check("b_rand_gen", get_gen(1), gen_exp);
      model_step();
      repeat (3) @(posedge clk);
      #1;
      check("b_rand_idle_busy", get_busy(1), 0);
      check("b_rand_idle_done", get_done(1), 0);
      check_grid(1, "b_rand");
    end

    start_op(1, 1, 1, 0, 0, 0, 0);
    wait_done(1, 80, -1, cyc);
    check("b_clr_wins_lat", cyc, 64);
    check("b_clr_wins_gen", get_gen(1), 0);
    model_seed(8);
    check_grid(1, "b_clr_wins");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
